// File: rtl/score_pkg.sv
// Shared definitions for the score bank controller: FSM state encoding and
// derivation of the reserved team-maximum slot and the saturated score value.
package score_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_LOAD_MAX,
        ST_WAIT_USER,
        ST_LOAD_IND,
        ST_WAIT_AUTH,
        ST_PLAY,
        ST_WB_IND,
        ST_WB_MAX
    } state_t;

    function automatic int max_slot(input int id_w);
        return (1 << id_w) - 1;
    endfunction

    function automatic int score_max(input int score_w);
        return (1 << score_w) - 1;
    endfunction

endpackage

// File: rtl/score_bank_ctrl_sat_add.sv
// Score plus level increment, clamped to the largest representable score.
module sat_add
    import score_pkg::*;
#(
    parameter int SCORE_W = 6,
    parameter int LEVEL_W = 4
) (
    input  logic [SCORE_W-1:0] a,
    input  logic [LEVEL_W-1:0] b,
    output logic [SCORE_W-1:0] sum,
    output logic               ovf
);

    logic [SCORE_W:0] wide;

    // One extra bit of headroom exposes the carry that triggers clamping.
    always_comb begin
        wide = {1'b0, a} + {{(SCORE_W + 1 - LEVEL_W){1'b0}}, b};
        ovf  = wide[SCORE_W];
        sum  = ovf ? SCORE_W'(score_max(SCORE_W)) : wide[SCORE_W-1:0];
    end

endmodule

// File: rtl/score_bank_ctrl.sv
// Session controller for a per-user score RAM with a shared team-maximum slot.
//   state      | meaning
//   CLEAR      | sweep 0 into every RAM address
//   LOAD_MAX   | read the team maximum from the top slot
//   WAIT_USER  | idle, waiting for login or clear request
//   LOAD_IND   | read the logged-in user's score
//   WAIT_AUTH  | waiting for authentication or early logout
//   PLAY       | apply win/lose events, track maximum and display
//   WB_IND     | write the user's score back
//   WB_MAX     | write the team maximum back
module score_bank_ctrl
    import score_pkg::*;
#(
    parameter int ID_W    = 3,
    parameter int SCORE_W = 6,
    parameter int LEVEL_W = 4,
    parameter int RD_LAT  = 2
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               login,
    input  logic [ID_W-1:0]    user_id,
    input  logic               auth,
    input  logic               logout,
    input  logic               win,
    input  logic               lose,
    input  logic [LEVEL_W-1:0] level_num,
    input  logic               disp_sel,
    input  logic               clear_req,
    input  logic [SCORE_W-1:0] ram_q,
    output logic [ID_W-1:0]    ram_addr,
    output logic [SCORE_W-1:0] ram_data,
    output logic               ram_wren,
    output logic [SCORE_W-1:0] disp,
    output logic               is_max,
    output logic               sat,
    output logic               busy
);

    localparam logic [ID_W-1:0] MAX_SLOT  = ID_W'(max_slot(ID_W));
    localparam int              WAIT_W    = $clog2(RD_LAT + 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RD_LAT);

    state_t              state, state_d;
    logic [ID_W:0]       sweep, sweep_d;
    logic [WAIT_W-1:0]   wait_cnt, wait_d;
    logic [ID_W-1:0]     user, user_d;
    logic [SCORE_W-1:0]  ind_score, ind_d;
    logic [SCORE_W-1:0]  team_max, max_d;
    logic [ID_W-1:0]     addr_d;
    logic [SCORE_W-1:0]  data_d;
    logic                wren_d;
    logic [SCORE_W-1:0]  disp_d;
    logic                is_max_d;
    logic                sat_d;
    logic [SCORE_W-1:0]  win_sum;
    logic                win_ovf;

    sat_add #(
        .SCORE_W(SCORE_W),
        .LEVEL_W(LEVEL_W)
    ) u_sat_add (
        .a  (ind_score),
        .b  (level_num),
        .sum(win_sum),
        .ovf(win_ovf)
    );

    assign busy = !(state == ST_WAIT_USER || state == ST_PLAY);

    always_comb begin
        state_d  = state;
        sweep_d  = sweep;
        wait_d   = wait_cnt;
        user_d   = user;
        ind_d    = ind_score;
        max_d    = team_max;
        addr_d   = ram_addr;
        data_d   = ram_data;
        wren_d   = 1'b0;
        disp_d   = disp;
        is_max_d = is_max;
        sat_d    = sat;
        case (state)
            ST_CLEAR: begin
                // The extra MSB of sweep marks completion without wrapping to 0.
                if (sweep[ID_W]) begin
                    state_d = ST_LOAD_MAX;
                    addr_d  = MAX_SLOT;
                    wait_d  = WAIT_INIT;
                end else begin
                    addr_d  = sweep[ID_W-1:0];
                    data_d  = '0;
                    wren_d  = 1'b1;
                    sweep_d = sweep + (ID_W + 1)'(1);
                end
            end
            ST_LOAD_MAX: begin
                if (wait_cnt == '0) begin
                    max_d   = ram_q;
                    state_d = ST_WAIT_USER;
                end else begin
                    wait_d = wait_cnt - WAIT_W'(1);
                end
            end
            ST_WAIT_USER: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    sweep_d = '0;
                end else if (login && user_id != MAX_SLOT) begin
                    user_d  = user_id;
                    addr_d  = user_id;
                    wait_d  = WAIT_INIT;
                    state_d = ST_LOAD_IND;
                end
            end
            ST_LOAD_IND: begin
                if (wait_cnt == '0) begin
                    ind_d   = ram_q;
                    sat_d   = 1'b0;
                    state_d = ST_WAIT_AUTH;
                end else begin
                    wait_d = wait_cnt - WAIT_W'(1);
                end
            end
            ST_WAIT_AUTH: begin
                if (logout) begin
                    state_d = ST_LOAD_MAX;
                    addr_d  = MAX_SLOT;
                    wait_d  = WAIT_INIT;
                end else if (auth) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Maximum tracking deliberately uses last cycle's ind_score.
                if (ind_score >= team_max) begin
                    max_d    = ind_score;
                    is_max_d = 1'b1;
                end else begin
                    is_max_d = 1'b0;
                end
                disp_d = disp_sel ? ind_score : team_max;
                if (logout) begin
                    state_d = ST_WB_IND;
                    addr_d  = user;
                    data_d  = ind_score;
                    wren_d  = 1'b1;
                end else if (lose) begin
                    ind_d = '0;
                end else if (win) begin
                    ind_d = win_sum;
                    if (win_ovf) sat_d = 1'b1;
                end
            end
            ST_WB_IND: begin
                state_d = ST_WB_MAX;
                addr_d  = MAX_SLOT;
                data_d  = (team_max >= ind_score) ? team_max : ind_score;
                wren_d  = 1'b1;
            end
            ST_WB_MAX: begin
                state_d = ST_LOAD_MAX;
                addr_d  = MAX_SLOT;
                wait_d  = WAIT_INIT;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= ST_CLEAR;
            sweep     <= '0;
            wait_cnt  <= '0;
            user      <= '0;
            ind_score <= '0;
            team_max  <= '0;
            ram_addr  <= '0;
            ram_data  <= '0;
            ram_wren  <= 1'b0;
            disp      <= '0;
            is_max    <= 1'b0;
            sat       <= 1'b0;
        end else begin
            state     <= state_d;
            sweep     <= sweep_d;
            wait_cnt  <= wait_d;
            user      <= user_d;
            ind_score <= ind_d;
            team_max  <= max_d;
            ram_addr  <= addr_d;
            ram_data  <= data_d;
            ram_wren  <= wren_d;
            disp      <= disp_d;
            is_max    <= is_max_d;
            sat       <= sat_d;
        end
    end

endmodule

// File: tb/tb_score_bank_ctrl.sv
// Directed bench for score_bank_ctrl: a session-level model predicts every
// output each cycle, and a few literal checks pin key values.
module tb_score_bank_ctrl;

    localparam int ID_W    = 3;
    localparam int SCORE_W = 6;
    localparam int LEVEL_W = 4;
    localparam int RD_LAT  = 2;
    localparam int SMAX    = 63;
    localparam int MSLOT   = 7;

    logic               clock;
    logic               rst;
    logic               login;
    logic [ID_W-1:0]    user_id;
    logic               auth;
    logic               logout;
    logic               win;
    logic               lose;
    logic [LEVEL_W-1:0] level_num;
    logic               disp_sel;
    logic               clear_req;
    logic [SCORE_W-1:0] ram_q;
    logic [ID_W-1:0]    ram_addr;
    logic [SCORE_W-1:0] ram_data;
    logic               ram_wren;
    logic [SCORE_W-1:0] disp;
    logic               is_max;
    logic               sat;
    logic               busy;

    score_bank_ctrl #(
        .ID_W(ID_W), .SCORE_W(SCORE_W), .LEVEL_W(LEVEL_W), .RD_LAT(RD_LAT)
    ) dut (
        .clock(clock), .rst(rst), .login(login), .user_id(user_id), .auth(auth),
        .logout(logout), .win(win), .lose(lose), .level_num(level_num),
        .disp_sel(disp_sel), .clear_req(clear_req), .ram_q(ram_q),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
        .disp(disp), .is_max(is_max), .sat(sat), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM with RD_LAT cycles from address to data.
    logic [SCORE_W-1:0] mem  [0:7];
    logic [SCORE_W-1:0] pipe [0:RD_LAT-1];
    always @(posedge clock) begin
        pipe[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        if (ram_wren) mem[ram_addr] = ram_data;
    end
    assign ram_q = pipe[RD_LAT-1];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    int exp_mem [0:7];
    int m_ind, m_max, m_user;
    int e_addr, e_data, e_disp;
    logic e_busy, e_wren, e_ismax, e_sat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            chk("busy", busy, e_busy);
            chk("ram_wren", ram_wren, e_wren);
            if (e_wren) begin
                chk("ram_addr", ram_addr, e_addr);
                chk("ram_data", ram_data, e_data);
            end
            chk("disp", disp, e_disp);
            chk("is_max", is_max, e_ismax);
            chk("sat", sat, e_sat);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_state();
        e_busy = 1; e_wren = 0; e_disp = 0; e_ismax = 0; e_sat = 0;
        m_ind = 0; m_max = 0;
    endtask

    task automatic finish_load_max();
        repeat (RD_LAT) tick();
        tick();
        e_busy = 0;
        m_max  = exp_mem[MSLOT];
    endtask

    // Entered with the controller in the first (idle) cycle of a clear sweep.
    task automatic sweep_and_load();
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 0) chk("sweep_first_addr_lit", ram_addr, 0);
            e_wren = 1; e_addr = k; e_data = 0;
            exp_mem[k] = 0;
        end
        tick();
        e_wren = 0;
        finish_load_max();
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        reset_state();
        chk_on = 1;
        rst = 0;
        sweep_and_load();
    endtask

    task automatic do_login(input int u);
        login = 1; user_id = 3'(u);
        tick();
        login = 0;
        if (u == MSLOT) return;
        m_user = u;
        e_busy = 1;
        repeat (RD_LAT) tick();
        tick();
        m_ind = exp_mem[u];
        e_sat = 0;
    endtask

    task automatic do_auth();
        auth = 1;
        tick();
        e_busy = 0;
    endtask

    task automatic play(input bit w, input bit l, input bit lo, input int lvl, input bit sel);
        int old_ind, old_max, total;
        win = w; lose = l; logout = lo; level_num = 4'(lvl); disp_sel = sel;
        if (lo) auth = 0;
        tick();
        win = 0; lose = 0; logout = 0;
        old_ind = m_ind;
        old_max = m_max;
        e_ismax = (old_ind >= old_max);
        if (old_ind > old_max) m_max = old_ind;
        e_disp = sel ? old_ind : old_max;
        if (lo) begin
            e_busy = 1; e_wren = 1; e_addr = m_user; e_data = old_ind;
            exp_mem[m_user] = old_ind;
        end else if (l) begin
            m_ind = 0;
        end else if (w) begin
            total = old_ind + lvl;
            if (total > SMAX) begin
                m_ind = SMAX;
                e_sat = 1;
            end else begin
                m_ind = total;
            end
        end
    endtask

    // From the write-back of the user slot through reload of the team maximum.
    task automatic finish_wb(input int want_max);
        int top;
        tick();
        top = (m_max > m_ind) ? m_max : m_ind;
        e_addr = MSLOT; e_data = top;
        exp_mem[MSLOT] = top;
        if (want_max >= 0) begin
            chk("wbmax_addr_lit", ram_addr, MSLOT);
            chk("wbmax_data_lit", ram_data, want_max);
        end
        tick();
        e_wren = 0;
        finish_load_max();
    endtask

    initial begin
        rst = 1; login = 0; user_id = '0; auth = 0; logout = 0; win = 0; lose = 0;
        level_num = '0; disp_sel = 0; clear_req = 0;
        for (int i = 0; i < 8; i++) mem[i] = 6'(i * 7 + 11);
        for (int i = 0; i < 8; i++) exp_mem[i] = -1;

        do_reset();
        chk("busy_after_load_lit", busy, 0);

        // Build up stored scores: user 1 reaches 9, user 3 reaches 5.
        do_login(1); do_auth();
        play(1, 0, 0, 9, 1);
        play(0, 0, 0, 0, 1);
        play(0, 0, 1, 0, 1);
        finish_wb(9);
        do_login(3); do_auth();
        play(1, 0, 0, 5, 0);
        play(0, 0, 1, 0, 0);
        finish_wb(9);

        // Stored 5, team max 9, win 4 -> ties the maximum one cycle later.
        do_login(3); do_auth();
        play(0, 0, 0, 0, 0);
        play(1, 0, 0, 4, 0);
        chk("is_max_lag_lit", is_max, 0);
        play(0, 0, 0, 0, 0);
        chk("is_max_tie_lit", is_max, 1);
        chk("disp_team_max_lit", disp, 9);
        play(0, 1, 0, 0, 1);
        play(0, 0, 0, 0, 1);
        chk("is_max_after_lose_lit", is_max, 0);
        clear_req = 1;
        play(1, 0, 0, 3, 1);
        clear_req = 0;
        // Simultaneous win, lose and logout: only logout acts.
        play(1, 1, 1, 15, 1);
        chk("wbind_addr_lit", ram_addr, 3);
        chk("wbind_data_lit", ram_data, 3);
        finish_wb(9);

        // Saturation: user 2 builds 60, then wins 7 and 15.
        do_login(2); do_auth();
        repeat (4) play(1, 0, 0, 15, 1);
        play(0, 0, 1, 0, 1);
        finish_wb(60);
        do_login(2); do_auth();
        play(1, 0, 0, 7, 1);
        chk("sat_set_lit", sat, 1);
        play(1, 0, 0, 15, 1);
        chk("sat_hold_disp_lit", disp, 63);
        play(0, 0, 0, 0, 1);
        play(0, 1, 0, 0, 1);
        play(0, 0, 0, 0, 1);
        chk("sat_sticky_after_lose_lit", sat, 1);
        play(0, 0, 1, 0, 1);
        finish_wb(63);

        // Illegal login to the team slot is ignored.
        do_login(MSLOT);
        repeat (3) tick();
        chk("illegal_login_busy_lit", busy, 0);

        // New session clears sat; logout before auth writes nothing.
        do_login(2);
        chk("sat_cleared_on_load_lit", sat, 0);
        logout = 1;
        tick();
        logout = 0;
        finish_load_max();

        // Clear request wipes the bank and team maximum.
        clear_req = 1;
        tick();
        clear_req = 0;
        e_busy = 1;
        sweep_and_load();

        // Reset during the user write-back: no team-slot write follows.
        do_login(4); do_auth();
        play(1, 0, 0, 6, 1);
        play(0, 0, 1, 0, 1);
        do_reset();

        do_login(1); do_auth();
        play(0, 0, 0, 0, 1);
        play(1, 0, 0, 2, 0);
        play(0, 0, 1, 0, 1);
        finish_wb(2);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
